// File: rtl/divider_iter_rv.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU and their W forms.
// Signed operands are reduced to magnitudes at accept time. The sign of the result is
// reapplied when the last CALC cycle completes. One operation is in flight at a time.
module divider_iter_rv #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned BITS_PER_CYCLE = 2,
    parameter int unsigned SUPPORT_W      = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [1:0]      op_sel_i,
    input  logic            word_i,
    input  logic            kill_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o
);
    localparam int unsigned CntW = $clog2(XLEN / BITS_PER_CYCLE) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    logic [XLEN-1:0]   quo_q;     // dividend bits shift out the top, quotient bits shift in
    logic [XLEN:0]     rem_q;
    logic [XLEN-1:0]   div_q;
    logic              neg_q;
    logic              is_rem_q;
    logic              word_q;
    logic [XLEN-1:0]   result_q;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = v[31];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = 1'b0;
        return r;
    endfunction

    logic            accept, word_eff, is_signed, is_rem, sign_a, sign_b, special;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_res, min_val, special_res, dividend_init;
    logic [CntW-1:0] cnt_init;

    assign req_ready_o  = (state_q == StIdle) && rst_ni;
    assign resp_valid_o = (state_q == StDone);
    assign result_o     = result_q;
    assign accept       = req_valid_i && req_ready_o && !kill_i;

    // Decode the request into magnitudes, signs and the special-case result.
    always_comb begin
        word_eff  = (SUPPORT_W != 0) && word_i;
        is_signed = ~op_sel_i[0];
        is_rem    = op_sel_i[1];
        if (word_eff) begin
            a_ext = is_signed ? sext32(op_a_i) : zext32(op_a_i);
            b_ext = is_signed ? sext32(op_b_i) : zext32(op_b_i);
        end else begin
            a_ext = op_a_i;
            b_ext = op_b_i;
        end
        sign_a  = is_signed && a_ext[XLEN-1];
        sign_b  = is_signed && b_ext[XLEN-1];
        a_mag   = sign_a ? -a_ext : a_ext;
        b_mag   = sign_b ? -b_ext : b_ext;
        min_val = word_eff ? ({XLEN{1'b1}} << 31) : ({{(XLEN-1){1'b0}}, 1'b1} << (XLEN - 1));
        a_res   = word_eff ? sext32(op_a_i) : op_a_i;
        if (b_ext == '0) begin
            special     = 1'b1;
            special_res = is_rem ? a_res : '1;
        end else if (is_signed && (b_ext == '1) && (a_ext == min_val)) begin
            special     = 1'b1;
            special_res = is_rem ? '0 : a_res;
        end else begin
            special     = 1'b0;
            special_res = '0;
        end
        // W-mode dividend is left-aligned so only 32 bits are consumed.
        dividend_init = word_eff ? (a_mag << (XLEN - 32)) : a_mag;
        cnt_init      = word_eff ? CntW'(32 / BITS_PER_CYCLE - 1)
                                 : CntW'(XLEN / BITS_PER_CYCLE - 1);
    end

    logic [XLEN:0]   rem_t;
    logic [XLEN-1:0] quo_t, mag, signed_res, final_res;

    // BITS_PER_CYCLE restoring steps, then sign fix-up of the selected result.
    always_comb begin
        rem_t = rem_q;
        quo_t = quo_q;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            rem_t = {rem_t[XLEN-1:0], quo_t[XLEN-1]};
            quo_t = {quo_t[XLEN-2:0], 1'b0};
            if (rem_t >= {1'b0, div_q}) begin
                rem_t    = rem_t - {1'b0, div_q};
                quo_t[0] = 1'b1;
            end
        end
        mag        = is_rem_q ? rem_t[XLEN-1:0] : quo_t;
        signed_res = neg_q ? -mag : mag;
        final_res  = word_q ? sext32(signed_res) : signed_res;
    end

    // Next-state logic; kill overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = special ? StDone : StCalc;
            StCalc: if (cnt_q == '0) state_d = StDone;
            StDone: if (resp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (kill_i) state_d = StIdle;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Datapath: load on accept, iterate in CALC, capture result on the last step.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            neg_q    <= 1'b0;
            is_rem_q <= 1'b0;
            word_q   <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            cnt_q    <= cnt_init;
            quo_q    <= dividend_init;
            rem_q    <= '0;
            div_q    <= b_mag;
            neg_q    <= is_rem ? sign_a : (sign_a ^ sign_b);
            is_rem_q <= is_rem;
            word_q   <= word_eff;
            if (special) result_q <= special_res;
        end else if ((state_q == StCalc) && !kill_i) begin
            cnt_q <= cnt_q - 1'b1;
            quo_q <= quo_t;
            rem_q <= rem_t;
            if (cnt_q == '0) result_q <= final_res;
        end
    end

endmodule
